// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encoding and default frame parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEF_SIZEDATA   = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICKS   = 16;

  // PARITY keeps its encoding even when the parity build option is off,
  // so RX/TX stages always agree on the state numbering.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module   : uart_tx_if
// Brief    : Request/serial-line bundle between the TX driver and uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int SIZEDATA = DEF_SIZEDATA
);

  logic                i_tick;
  logic                i_tx_start;
  logic [SIZEDATA-1:0] i_tx_data;
  logic                o_tx;
  logic                o_tx_busy;
  logic                o_tx_done;

  modport master (
    output i_tick,
    output i_tx_start,
    output i_tx_data,
    input  o_tx,
    input  o_tx_busy,
    input  o_tx_done
  );

  modport slave (
    input  i_tick,
    input  i_tx_start,
    input  i_tx_data,
    output o_tx,
    output o_tx_busy,
    output o_tx_done
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter, start + SIZEDATA data (LSB first) + stop bits.
//            Define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int SIZEDATA   = DEF_SIZEDATA,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICKS   = DEF_SB_TICKS
) (
  input  logic       i_clock,
  input  logic       i_reset,
  uart_tx_if.slave   bus
);

  localparam int TICK_MAX = max2(OVERSAMPLE, SB_TICKS);
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int BIT_W    = $clog2(SIZEDATA + 1);

  localparam logic [TICK_W-1:0] BIT_LAST_TICK  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST_TICK = TICK_W'(SB_TICKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT       = BIT_W'(SIZEDATA - 1);

  tx_state_e           state_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [SIZEDATA-1:0] shreg_q;
  logic [SIZEDATA-1:0] shreg_d;
  logic                tx_q;
  logic                busy_q;
  logic                done_q;
  logic                bit_end_d;
  logic                stop_end_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q;
`endif

  assign shreg_d    = shreg_q >> 1;
  assign bit_end_d  = bus.i_tick && (tick_cnt_q == BIT_LAST_TICK);
  assign stop_end_d = bus.i_tick && (tick_cnt_q == STOP_LAST_TICK);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          // Accept without waiting for a tick; a tick on this edge is not counted.
          if (bus.i_tx_start) begin
            shreg_q    <= bus.i_tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^bus.i_tx_data;
`endif
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= ST_START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_end_d) begin
            tick_cnt_q <= '0;
            state_q    <= ST_DATA;
            tx_q       <= shreg_q[0];
          end else if (bus.i_tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end_d) begin
            tick_cnt_q <= '0;
            shreg_q    <= shreg_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= ST_PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= ST_STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shreg_d[0];
            end
          end else if (bus.i_tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_d) begin
            tick_cnt_q <= '0;
            state_q    <= ST_STOP;
            tx_q       <= 1'b1;
          end else if (bus.i_tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          tx_q <= 1'b1;
          if (stop_end_d) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else if (bus.i_tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end

        default: begin
          // Unreachable encodings (including PARITY when it is compiled out).
          state_q    <= ST_IDLE;
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_tx      = tx_q;
  assign bus.o_tx_busy = busy_q;
  assign bus.o_tx_done = done_q;

  a_busy_tracks_state : assert property (
    @(posedge i_clock) disable iff (i_reset)
    busy_q == (state_q != ST_IDLE)
  );

  a_done_means_idle_line : assert property (
    @(posedge i_clock) disable iff (i_reset)
    done_q |-> (!busy_q && tx_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx (table vectors + random frames).
//            Honours UART_TX_PARITY_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int SB = 16;

`ifdef UART_TX_PARITY_EN
  localparam int          NSEG = 11;
  localparam logic [15:0] S55  = 16'h04AA;
  localparam logic [15:0] S80  = 16'h0700;
  localparam logic [15:0] SFF  = 16'h05FE;
  localparam logic [15:0] S01  = 16'h0602;
`else
  localparam int          NSEG = 10;
  localparam logic [15:0] S55  = 16'h02AA;
  localparam logic [15:0] S80  = 16'h0300;
  localparam logic [15:0] SFF  = 16'h03FE;
  localparam logic [15:0] S01  = 16'h0202;
`endif
  localparam int FT = (NSEG - 1) * OS + SB;

  typedef struct {
    logic [7:0]  data;
    int          mode;
    int          coin;
    logic [15:0] seq;
    int          nseg;
    int          ticks;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;
  int   tick_mode;

  always #5 clk = ~clk;

  uart_tx_if #(.SIZEDATA(8)) bus();

  uart_tx #(
    .SIZEDATA  (8),
    .OVERSAMPLE(OS),
    .SB_TICKS  (SB)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // Tick source: mode 0 = every 2 clocks, mode 1 = random ~1/3 duty.
  initial begin
    bus.i_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_mode == 0) bus.i_tick = ~bus.i_tick;
      else                bus.i_tick = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(output logic t);
    @(negedge clk); #1;
    t = bus.i_tick;
    @(posedge clk); #1;
  endtask

  // Reference frame: segment levels in time order, each OS ticks, stop SB ticks.
  function automatic void model(input logic [7:0] d, output logic [15:0] seq, output int nseg);
    seq = '0;
    for (int i = 0; i < 8; i++) seq[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    seq[9]  = ^d;
    seq[10] = 1'b1;
    nseg    = 11;
`else
    seq[9]  = 1'b1;
    nseg    = 10;
`endif
  endfunction

  task automatic start_frame(input logic [7:0] d, input int coin, input logic keep);
    int tries = 0;
    @(negedge clk); #1;
    while (coin >= 0 && bus.i_tick !== coin[0] && tries < 16) begin
      @(negedge clk); #1;
      tries++;
    end
    bus.i_tx_data  = d;
    bus.i_tx_start = 1'b1;
    @(posedge clk); #1;
    chk("start_tx_low", 32'(bus.o_tx), 32'd0);
    chk("start_busy", 32'(bus.o_tx_busy), 32'd1);
    if (!keep) bus.i_tx_start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] seq, input int nseg,
                             input int ticks, input logic perturb, input logic hold,
                             input logic [7:0] next_data);
    int   n     = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   idx;
    int   total = (nseg - 1) * OS + SB;
    logic t;
    logic e;
    logic seen  = 1'b0;
    while (!seen && cyc < total * 8) begin
      if (perturb) begin
        bus.i_tx_start = 1'($urandom_range(0, 1));
        bus.i_tx_data  = 8'($urandom);
      end
      step(t);
      cyc++;
      if (t) n++;
      if (bus.o_tx_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        idx = n / OS;
        if (idx > nseg - 1) idx = nseg - 1;
        e = (n >= total) ? 1'b1 : seq[idx];
        if (bus.o_tx !== e || bus.o_tx_busy !== 1'b1) bad++;
      end
    end
    chk({tag, "_wave_bad_cycles"}, bad, 0);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_ticks"}, n, ticks);
    chk({tag, "_done_tx_busy"}, 32'({bus.o_tx, bus.o_tx_busy}), 32'b10);
    bus.i_tx_start = hold;
    bus.i_tx_data  = next_data;
    step(t);
    chk({tag, "_done_one_clock"}, 32'(bus.o_tx_done), 32'd0);
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    int   bad = 0;
    logic t;
    for (int i = 0; i < cycles; i++) begin
      step(t);
      if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0 || bus.o_tx_done !== 1'b0) bad++;
    end
    chk({tag, "_idle_quiet"}, bad, 0);
  endtask

  initial begin
    vec_t        vec[4];
    logic [15:0] s;
    int          ns;
    int          n;
    int          cyc;
    int          bad;
    logic        t;
    logic [7:0]  d;

    vec[0] = '{data: 8'h55, mode: 0, coin: 1,  seq: S55, nseg: NSEG, ticks: FT};
    vec[1] = '{data: 8'h80, mode: 0, coin: 0,  seq: S80, nseg: NSEG, ticks: FT};
    vec[2] = '{data: 8'hFF, mode: 1, coin: 1,  seq: SFF, nseg: NSEG, ticks: FT};
    vec[3] = '{data: 8'h01, mode: 1, coin: -1, seq: S01, nseg: NSEG, ticks: FT};

    checks         = 0;
    errors         = 0;
    tick_mode      = 0;
    rst            = 1'b1;
    bus.i_tx_start = 1'b0;
    bus.i_tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(bus.o_tx), 32'd1);
    chk("reset_busy", 32'(bus.o_tx_busy), 32'd0);
    chk("reset_done", 32'(bus.o_tx_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_quiet("post_reset", 4);

    for (int i = 0; i < 4; i++) begin
      tick_mode = vec[i].mode;
      start_frame(vec[i].data, vec[i].coin, 1'b0);
      check_frame($sformatf("vec%0d", i), vec[i].seq, vec[i].nseg, vec[i].ticks,
                  1'b0, 1'b0, 8'h00);
      chk($sformatf("vec%0d_after_tx_busy", i), 32'({bus.o_tx, bus.o_tx_busy}), 32'b10);
    end

    // Start held across two frames; input data changes mid-frame.
    tick_mode = 0;
    start_frame(8'hA3, -1, 1'b1);
    bus.i_tx_data = 8'h3C;
    model(8'hA3, s, ns);
    check_frame("b2b_a3", s, ns, (ns - 1) * OS + SB, 1'b0, 1'b1, 8'h3C);
    chk("b2b_restart_tx", 32'(bus.o_tx), 32'd0);
    chk("b2b_restart_busy", 32'(bus.o_tx_busy), 32'd1);
    bus.i_tx_start = 1'b0;
    bus.i_tx_data  = 8'h55;
    model(8'h3C, s, ns);
    check_frame("b2b_3c", s, ns, (ns - 1) * OS + SB, 1'b0, 1'b0, 8'h00);
    idle_quiet("b2b", 4);

    // Abort during data bit 4 of 0xFF with an asynchronous reset.
    tick_mode = 0;
    start_frame(8'hFF, -1, 1'b0);
    n   = 0;
    cyc = 0;
    while (n < OS * 5 + 8 && cyc < 2000) begin
      step(t);
      cyc++;
      if (t) n++;
    end
    chk("abort_reached_bit4", n, OS * 5 + 8);
    chk("abort_pre_busy", 32'(bus.o_tx_busy), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_tx_immediate", 32'(bus.o_tx), 32'd1);
    chk("abort_busy_immediate", 32'(bus.o_tx_busy), 32'd0);
    chk("abort_done_immediate", 32'(bus.o_tx_done), 32'd0);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.o_tx_done !== 1'b0 || bus.o_tx_busy !== 1'b0 || bus.o_tx !== 1'b1) bad++;
    end
    chk("abort_held_quiet", bad, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_quiet("abort_release", 6);
    start_frame(8'h01, -1, 1'b0);
    check_frame("abort_next", S01, NSEG, FT, 1'b0, 1'b0, 8'h00);
    idle_quiet("abort_next", 3);

    // Random frames with start/data toggling while busy; only one frame each.
    for (int k = 0; k < 6; k++) begin
      d         = 8'($urandom);
      tick_mode = int'($urandom_range(0, 1));
      start_frame(d, int'($urandom_range(0, 1)), 1'b0);
      model(d, s, ns);
      check_frame($sformatf("rnd%0d", k), s, ns, (ns - 1) * OS + SB, 1'b1, 1'b0,
                  8'($urandom));
      idle_quiet($sformatf("rnd%0d", k), 5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter SIZEDATA, default 8, data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, baud ticks per bit (start, data and parity bits).
REQ-003 Parameter SB_TICKS, default 16, baud ticks for the stop bit.
REQ-004 i_clock  input  1  single system clock; all logic on rising edge.
REQ-005 i_reset  input  1  reset, asynchronous and active-high.
REQ-006 i_tick  input  1  one-clock baud-tick strobe from the baud generator at OVERSAMPLE x baud rate.
REQ-007 i_tx_start  input  1  request to send i_tx_data, level or pulse, from the ALU/RX interface stage tx-signal output.
REQ-008 i_tx_data  input  SIZEDATA  byte to transmit (ALU result).
REQ-009 o_tx  output  1  serial line; idle high.
REQ-010 o_tx_busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-011 o_tx_done  output  1  one-clock pulse at frame completion.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP, held in a state register.
REQ-013 In IDLE, i_tx_start=1 on any clock edge SHALL latch i_tx_data into a shift register, clear the tick and bit counters, and enter START; i_tick need not be present.
REQ-014 o_tx SHALL go low on the clock after start acceptance (1-cycle latency).
REQ-015 i_tx_start outside IDLE SHALL be ignored; data changes after acceptance SHALL NOT affect the frame.
REQ-016 The tick counter SHALL count only on i_tick=1; START, DATA and PARITY SHALL each last exactly OVERSAMPLE ticks; STOP SHALL last SB_TICKS ticks.
REQ-017 DATA SHALL shift out SIZEDATA bits LSB first; the bit counter SHALL wrap to 0 and the FSM SHALL leave DATA after bit SIZEDATA-1.
REQ-018 STOP SHALL drive o_tx=1; on its final tick the FSM SHALL return to IDLE, pulse o_tx_done for one clock, and drop o_tx_busy in the same cycle.
REQ-019 If i_tx_start is still high on the clock after the done pulse, a new frame SHALL start (back-to-back with no idle gap beyond 1 clock).
REQ-020 An i_tick coincident with start acceptance SHALL NOT be counted toward START.
REQ-021 Illegal state encodings SHALL recover to IDLE with o_tx=1 on the next clock.

Reset
REQ-022 i_reset=1 SHALL immediately force state IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, counters 0 and shift register 0, including mid-frame; no done pulse for an aborted frame.
REQ-023 After reset release, the first accepted i_tx_start SHALL produce a complete, well-formed frame.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, PARITY SHALL follow DATA and send even parity (XOR of the latched data) for OVERSAMPLE ticks; when undefined, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Structure
REQ-025 Package uart_pkg SHALL hold the state encoding constants and the default SIZEDATA/OVERSAMPLE/SB_TICKS values shared with the RX and interface stages.
REQ-026 No sub-module inside uart_tx; the tick comes from the sibling uart_baud_gen instantiated at top level.

Verification (i_tick every 2 clocks, defaults)
REQ-027 Parity enabled, send 0x55 -> o_tx sequence 0,1,0,1,0,1,0,1,0,0(parity),1, each bit 16 ticks, frame 176 ticks, one o_tx_done pulse.
REQ-028 Parity disabled, send 0x80 -> 0,0,0,0,0,0,0,0,1,1 (start, 7 zeros, MSB 1, stop), frame 160 ticks.
REQ-029 i_tx_start held high continuously with data 0xA3 then 0x3C -> two consecutive frames, second start bit begins 1 clock after the first done pulse, data unchanged by mid-frame input changes.
REQ-030 Assert i_reset during data bit 4 of 0xFF -> o_tx=1 and o_tx_busy=0 immediately, no o_tx_done; next request 0x01 transmits correctly.
REQ-031 i_tx_start pulsed while busy -> ignored, frame count 1; i_tick coincident with acceptance -> START still lasts exactly 16 ticks.
